dmem_arbiter: RTL

//  Shares the single data port of the system memory (dread_*/dwrite_*) between two requesters:

---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_rsp_pipe.sv | 33 +++
 rtl/dmem_arbiter.sv | 79 +++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared widths and request/owner types for the data-memory arbiter
package dmem_pkg;
    localparam int DMEM_ADDR_W = 16;
    localparam int DMEM_DATA_W = 16;
    localparam int DMEM_BE_W   = DMEM_DATA_W / 8;

    typedef logic owner_t;

    typedef struct packed {
        logic [DMEM_BE_W-1:0]   we;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
    } dmem_req_t;
endpackage

// File: rtl/dmem_rsp_pipe.sv
// dmem_rsp_pipe: valid/owner tag delay line matching the memory read latency
module dmem_rsp_pipe
    import dmem_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   in_vld,
    input  owner_t in_own,
    output logic   out_vld,
    output owner_t out_own
);
    logic [DEPTH-1:0] vld_q, own_q;
    logic [DEPTH:0]   vld_sh, own_sh;

    always_comb begin
        vld_sh  = {vld_q, in_vld};
        own_sh  = {own_q, in_own};
        out_vld = vld_q[DEPTH-1];
        out_own = owner_t'(own_q[DEPTH-1]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
            own_q <= '0;
        end else begin
            vld_q <= vld_sh[DEPTH-1:0];
            own_q <= own_sh[DEPTH-1:0];
        end
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port fixed-priority arbiter with starvation guard for the data memory port
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W     = DMEM_ADDR_W,
    parameter int DATA_W     = DMEM_DATA_W,
    parameter int BE_W       = DMEM_BE_W,
    parameter int READ_LAT   = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [BE_W-1:0]   we0,
    input  logic [BE_W-1:0]   we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] dread_addr,
    output logic [ADDR_W-1:0] dwrite_addr,
    output logic [DATA_W-1:0] dwrite_data,
    output logic [BE_W-1:0]   dwrite_en,
    input  logic [DATA_W-1:0] dread_data
);
    localparam int SC_W = $clog2(STARVE_MAX + 1);

    logic [SC_W-1:0]   starve_cnt;
    logic              starved, granted, is_wr, rd_go, out_vld;
    owner_t            out_own;
    logic [BE_W-1:0]   sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    always_comb begin
        starved     = starve_cnt == SC_W'(STARVE_MAX);
        gnt1        = reset & req1 & (~req0 | starved);
        gnt0        = reset & req0 & ~gnt1;
        granted     = gnt0 | gnt1;
        sel_we      = gnt1 ? we1 : gnt0 ? we0 : '0;
        sel_addr    = gnt1 ? addr1 : gnt0 ? addr0 : '0;
        sel_wdata   = gnt1 ? wdata1 : gnt0 ? wdata0 : '0;
        is_wr       = |sel_we;
        rd_go       = granted & ~is_wr;
        dwrite_en   = sel_we;
        dwrite_addr = is_wr ? sel_addr : '0;
        dwrite_data = is_wr ? sel_wdata : '0;
        dread_addr  = rd_go ? sel_addr : '0;
        rvalid0     = out_vld & ~out_own;
        rvalid1     = out_vld & out_own;
        rdata0      = rvalid0 ? dread_data : '0;
        rdata1      = rvalid1 ? dread_data : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            starve_cnt <= '0;
        else if (gnt1 || !req1)
            starve_cnt <= '0;
        else if (!starved)
            starve_cnt <= starve_cnt + SC_W'(1);
    end

    dmem_rsp_pipe #(.DEPTH(READ_LAT)) u_rsp_pipe (
        .clk     (clk),
        .reset   (reset),
        .in_vld  (rd_go),
        .in_own  (owner_t'(gnt1)),
        .out_vld (out_vld),
        .out_own (out_own)
    );
endmodule
